// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults (640x480@60) and derived totals, reused by the
// timing generator and the pixel generator.
package vga_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_CNT_W    = 12;

  function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  localparam int VGA_H_TOTAL = axis_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
  localparam int VGA_V_TOTAL = axis_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-MOD counter for one screen axis. Exposes the next count so callers
// can register decodes in step with the count itself.
module vga_axis_counter #(
  parameter int MOD   = 800,
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MOD - 1);

  // Next count and wrap strobe; wrap only fires on an enabled terminal count
  always_comb begin
    wrap = en && (count == LAST);
    if (!en) begin
      count_next = count;
    end else if (count == LAST) begin
      count_next = '0;
    end else begin
      count_next = count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with sync, active-area and
// line/frame strobes, all registered so they line up with the counts.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CNT_W    = VGA_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_en,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_zero_param
    $fatal(1, "vga_timing_gen: porch, sync and active widths must be non-zero");
  end
  if (longint'(H_TOTAL) > (longint'(1) << CNT_W) ||
      longint'(V_TOTAL) > (longint'(1) << CNT_W)) begin : g_cnt_overflow
    $fatal(1, "vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VS_START  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;
  logic             h_wrap;
  logic             v_wrap;
  logic             hs_on;
  logic             vs_on;
  logic             act_on;

  vga_axis_counter #(.MOD(H_TOTAL), .CNT_W(CNT_W)) u_h_axis (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (pix_en),
    .count      (hcount),
    .count_next (h_next),
    .wrap       (h_wrap)
  );

  // The vertical axis advances only on a horizontal wrap, so its wrap is a frame wrap
  vga_axis_counter #(.MOD(V_TOTAL), .CNT_W(CNT_W)) u_v_axis (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (h_wrap),
    .count      (vcount),
    .count_next (v_next),
    .wrap       (v_wrap)
  );

  // Decode from the next counts so the registered outputs match the new counts
  always_comb begin
    hs_on  = (h_next >= HS_START) && (h_next < HS_END);
    vs_on  = (v_next >= VS_START) && (v_next < VS_END);
    act_on = (h_next < H_ACT_END) && (v_next < V_ACT_END);
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      active      <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hs_on ? HS_POL : ~HS_POL;
      vsync       <= vs_on ? VS_POL : ~VS_POL;
      active      <= act_on;
      line_start  <= h_wrap;
      frame_start <= v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance and a tiny 8x4 instance
// with inverted sync polarity, checked against a position-from-cycle-count model.
module tb_vga_timing_gen;

  localparam int HA = 640, HF = 16, HS = 96, VA = 480, VF = 10, VS = 2;
  localparam int HT = 800, VT = 525;
  localparam int SHA = 8, SHF = 2, SHS = 2, SVA = 4, SVF = 1, SVS = 1;
  localparam int SHT = 14, SVT = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_en = 1'b0;
  logic [11:0] d_hcount, d_vcount, s_hcount, s_vcount;
  logic        d_hsync, d_vsync, d_active, d_ls, d_fs;
  logic        s_hsync, s_vsync, s_active, s_ls, s_fs;

  int   checks = 0, errors = 0, cyc = 0;
  int   n_def = 0, n_sml = 0;
  logic els_d = 1'b0, efs_d = 1'b0, els_s = 1'b0, efs_s = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen u_def (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .hcount(d_hcount), .vcount(d_vcount), .hsync(d_hsync), .vsync(d_vsync),
    .active(d_active), .line_start(d_ls), .frame_start(d_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_sml (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .hcount(s_hcount), .vcount(s_vcount), .hsync(s_hsync), .vsync(s_vsync),
    .active(s_active), .line_start(s_ls), .frame_start(s_fs)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic sync_exp(input int c, input int lo, input int w, input logic pol);
    return (c >= lo && c < lo + w) ? pol : ~pol;
  endfunction

  // Raster position is just the number of enabled edges since reset, folded by the totals
  task automatic compare_all();
    int h, v;
    h = n_def % HT;
    v = (n_def / HT) % VT;
    chk("d_hcount", {20'd0, d_hcount}, h);
    chk("d_vcount", {20'd0, d_vcount}, v);
    chk("d_hsync", {31'd0, d_hsync}, {31'd0, sync_exp(h, HA + HF, HS, 1'b0)});
    chk("d_vsync", {31'd0, d_vsync}, {31'd0, sync_exp(v, VA + VF, VS, 1'b0)});
    chk("d_active", {31'd0, d_active}, (h < HA && v < VA) ? 1 : 0);
    chk("d_line_start", {31'd0, d_ls}, {31'd0, els_d});
    chk("d_frame_start", {31'd0, d_fs}, {31'd0, efs_d});
    h = n_sml % SHT;
    v = (n_sml / SHT) % SVT;
    chk("s_hcount", {20'd0, s_hcount}, h);
    chk("s_vcount", {20'd0, s_vcount}, v);
    chk("s_hsync", {31'd0, s_hsync}, {31'd0, sync_exp(h, SHA + SHF, SHS, 1'b1)});
    chk("s_vsync", {31'd0, s_vsync}, {31'd0, sync_exp(v, SVA + SVF, SVS, 1'b1)});
    chk("s_active", {31'd0, s_active}, (h < SHA && v < SVA) ? 1 : 0);
    chk("s_line_start", {31'd0, s_ls}, {31'd0, els_s});
    chk("s_frame_start", {31'd0, s_fs}, {31'd0, efs_s});
  endtask

  task automatic step(input logic r, input logic e);
    rst_n  = r;
    pix_en = e;
    @(posedge clk);
    cyc++;
    if (!r) begin
      n_def = 0; n_sml = 0;
      els_d = 1'b0; efs_d = 1'b0; els_s = 1'b0; efs_s = 1'b0;
    end else if (e) begin
      n_def++; n_sml++;
      els_d = (n_def % HT == 0);
      efs_d = (n_def % (HT * VT) == 0);
      els_s = (n_sml % SHT == 0);
      efs_s = (n_sml % (SHT * SVT) == 0);
    end else begin
      els_d = 1'b0; efs_d = 1'b0; els_s = 1'b0; efs_s = 1'b0;
    end
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int last, seen, found, nls, nfs, en_cnt;
    @(negedge clk);

    // reset holds regardless of pix_en
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("rst_hcount", {20'd0, d_hcount}, 0);
    chk("rst_hsync", {31'd0, d_hsync}, 1);
    chk("rst_active", {31'd0, d_active}, 1);
    chk("rst_s_hsync", {31'd0, s_hsync}, 0);

    // one full default line: 799 -> 0 with line_start and vcount 0 -> 1
    for (int i = 0; i < HT; i++) step(1'b1, 1'b1);
    chk("line_wrap_h", {20'd0, d_hcount}, 0);
    chk("line_wrap_v", {20'd0, d_vcount}, 1);
    chk("line_wrap_ls", {31'd0, d_ls}, 1);

    // 1-in-2 enable: line period in clocks
    last = -1; seen = 0;
    for (int i = 0; i < 5000; i++) begin
      step(1'b1, (i % 2 == 0));
      if (d_ls === 1'b1) begin
        if (last >= 0) chk("line_period", cyc - last, 1600);
        last = cyc;
        seen++;
      end
    end
    chk("line_period_seen", (seen >= 2) ? 1 : 0, 1);

    // random enable density
    for (int i = 0; i < 3000; i++) step(1'b1, ($urandom_range(0, 3) != 0));

    // mid-frame reset at hcount 700
    found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      step(1'b1, 1'b1);
      if (n_def % HT == 700) found = 1;
    end
    chk("reach_700", found, 1);
    step(1'b0, 1'($urandom_range(0, 1)));
    chk("mid_rst_h", {20'd0, d_hcount}, 0);
    chk("mid_rst_v", {20'd0, d_vcount}, 0);
    chk("mid_rst_vsync", {31'd0, d_vsync}, 1);
    chk("mid_rst_ls", {31'd0, d_ls}, 0);

    // small instance: first frame_start after exactly SHT*SVT enabled edges
    found = 0; en_cnt = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      step(1'b1, 1'b1);
      en_cnt++;
      if (s_fs === 1'b1) found = 1;
    end
    chk("s_first_frame", en_cnt, SHT * SVT);

    // five small frames with gaps in the enable
    nls = 0; nfs = 0; en_cnt = 0;
    for (int i = 0; i < 4000 && en_cnt < 5 * SHT * SVT; i++) begin
      logic e;
      e = ($urandom_range(0, 2) != 0);
      step(1'b1, e);
      if (e) en_cnt++;
      if (s_ls === 1'b1) nls++;
      if (s_fs === 1'b1) nfs++;
    end
    chk("s_line_count", nls, 5 * SVT);
    chk("s_frame_count", nfs, 5);

    // random enable with occasional reset pulses
    for (int i = 0; i < 6000; i++)
      step(($urandom_range(0, 499) != 0), ($urandom_range(0, 3) != 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
 H_ACTIVE, 640, visible pixels per line
 H_FP, 16, horizontal front porch
 H_SYNC, 96, hsync width
 H_BP, 48, horizontal back porch
 V_ACTIVE, 480, visible lines per frame
 V_FP, 10, vertical front porch
 V_SYNC, 2, vsync width
 V_BP, 33, vertical back porch
 HS_POL, 0, hsync active level
 VS_POL, 0, vsync active level
 CNT_W, 12, counter width
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
 clk  in  1  system clock
 rst_n  in  1  reset, synchronous, active-low
 pix_en  in  1  pixel-rate enable; counters advance only when high
 hcount  out  CNT_W  pixel index in line
 vcount  out  CNT_W  line index in frame
 hsync  out  1  horizontal sync at HS_POL when active
 vsync  out  1  vertical sync at VS_POL when active
 active  out  1  high inside visible area
 line_start  out  1  one-clk pulse, hcount wrapped to 0
 frame_start  out  1  one-clk pulse, both counts wrapped to 0
REQ-003 One clock, clk; reset is synchronous and active-low on rst_n.

Function
REQ-004 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP SHALL be derived constants.
REQ-005 On a clk edge with pix_en=1, hcount SHALL increment; at H_TOTAL-1 it SHALL wrap to 0.
REQ-006 vcount SHALL increment only on the edge where hcount wraps; at V_TOTAL-1 with hcount wrap it SHALL wrap to 0.
REQ-007 With pix_en=0, all outputs SHALL hold, except line_start and frame_start, which SHALL be 0.
REQ-008 hsync SHALL be HS_POL iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
REQ-009 vsync SHALL be VS_POL iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL.
REQ-010 active SHALL be 1 iff hcount < H_ACTIVE and vcount < V_ACTIVE.
REQ-011 Decoded outputs (REQ-008..010) SHALL be registered from next-state counts, so they change on the same edge as the count they describe: zero relative latency, glitch-free.
REQ-012 line_start SHALL be 1 for exactly the clk cycle following an hcount wrap edge; frame_start likewise for a combined h/v wrap; both SHALL be set in the same cycle at a frame wrap.
REQ-013 Counter arithmetic SHALL be unsigned at CNT_W bits; counts SHALL never exceed H_TOTAL-1 / V_TOTAL-1.
REQ-014 Elaboration SHALL fail if H_TOTAL or V_TOTAL exceeds 2^CNT_W, or if any porch/sync/active parameter is 0.

Reset
REQ-015 While rst_n=0 at a clk edge: hcount=0, vcount=0, hsync=~HS_POL, vsync=~VS_POL, active=1, line_start=0, frame_start=0, regardless of pix_en.
REQ-016 Reset asserted mid-frame SHALL abort the frame; after release, counting SHALL resume from (0,0) on the first pix_en edge, with no strobe until the first wrap.

Structure
REQ-017 Default 640x480@60 timing constants and the H_TOTAL/V_TOTAL derivations SHALL live in the shared package vga_timing_pkg, for reuse by the pixel generator.
REQ-018 A single sub-module, vga_axis_counter (parametrised modulus, enable in, wrap pulse out), SHALL be instantiated twice: horizontal driven by pix_en, vertical by the horizontal wrap.

Verification
REQ-019 Defaults, pix_en=1: hcount 799->0 with line_start=1 next cycle; vcount increments 0->1 on that edge.
REQ-020 Defaults: hsync=0 exactly for hcount 656..751; vsync=0 exactly for vcount 490..491; all other counts give 1.
REQ-021 Defaults: (639,479) gives active=1; (640,479) and (0,480) give active=0; frame_start pulses once per 420000 enabled cycles.
REQ-022 pix_en 1-in-2 pattern: counts advance only on enabled edges; strobes never assert on disabled cycles; line period = 1600 clk.
REQ-023 rst_n low for 1 cycle at (700,300): outputs match REQ-015 next cycle; restart at (0,0); first frame_start after 420000 enabled cycles.
REQ-024 HS_POL=1, VS_POL=1, H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1: H_TOTAL=14, V_TOTAL=7; hsync=1 for hcount 10..11; vsync=1 for vcount 5.
